// File: rtl/se_pkg.sv
// rtl/se_pkg.sv - shared types and width/constant helpers for the global-average-pool front end
package se_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        SCALE,
        HOLD
    } gap_state_e;

    // Signed accumulator width that can hold n samples of dw bits without overflow
    function automatic int acc_width(input int n, input int dw);
        return dw + $clog2(n);
    endfunction

    // round(2^shift / n), the fixed-point reciprocal of the frame size
    function automatic int recip_const(input int n, input int shift);
        return int'(((longint'(1) << shift) + longint'(n / 2)) / longint'(n));
    endfunction

    // Unsigned width needed to hold the reciprocal constant
    function automatic int recip_width(input int n, input int shift);
        return $clog2(recip_const(n, shift) + 1);
    endfunction

endpackage

// File: rtl/se_gap_stream_if.sv
// rtl/se_gap_stream_if.sv - pixel-in / mean-out handshake bundle; SE_GAP_FRAME_CHECK_EN adds s_last and frame_err
interface se_gap_stream_if #(
    parameter int IN_SIZE    = 16,
    parameter int DATA_WIDTH = 8
);
    logic                                s_valid;
    logic                                s_ready;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]  s_data;
    logic                                m_valid;
    logic                                m_ready;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]  m_data;
`ifdef SE_GAP_FRAME_CHECK_EN
    logic                                s_last;
    logic                                frame_err;
`endif

`ifdef SE_GAP_FRAME_CHECK_EN
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, frame_err
    );
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, frame_err
    );
`else
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
`endif

endinterface

// File: rtl/se_gap_lane.sv
// rtl/se_gap_lane.sv - one channel: running sum, reciprocal scale, round half up, saturate
module se_gap_lane
    import se_pkg::*;
#(
    parameter int N           = 3136,
    parameter int DATA_WIDTH  = 8,
    parameter int RECIP_SHIFT = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         acc_load,
    input  logic                         acc_add,
    input  logic                         scale,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] mean
);

    localparam int ACC_W   = acc_width(N, DATA_WIDTH);
    localparam int RECIP   = recip_const(N, RECIP_SHIFT);
    localparam int RECIP_W = recip_width(N, RECIP_SHIFT);
    localparam int PROD_W  = ACC_W + RECIP_W + 1;

    localparam logic signed [PROD_W-1:0] RECIP_S = PROD_W'(RECIP);
    localparam logic signed [PROD_W-1:0] HALF    = PROD_W'(longint'(1) << (RECIP_SHIFT - 1));
    localparam logic signed [PROD_W-1:0] MAX_V   = PROD_W'((longint'(1) << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] MIN_V   = ~MAX_V;

    logic signed [ACC_W-1:0]      acc;
    logic signed [PROD_W-1:0]     prod;
    logic signed [PROD_W-1:0]     rounded;
    logic signed [DATA_WIDTH-1:0] sat;

    // First beat of a frame loads the sum directly so no clear cycle is needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_load) begin
            acc <= ACC_W'(sample);
        end else if (acc_add) begin
            acc <= acc + ACC_W'(sample);
        end
    end

    // Mean = sum * recip, rounded half toward +inf, then saturated so a
    // reciprocal rounded up can never wrap a full-scale mean
    always_comb begin
        prod    = PROD_W'(acc) * RECIP_S;
        rounded = (prod + HALF) >>> RECIP_SHIFT;
        if (rounded > MAX_V) begin
            sat = MAX_V[DATA_WIDTH-1:0];
        end else if (rounded < MIN_V) begin
            sat = MIN_V[DATA_WIDTH-1:0];
        end else begin
            sat = rounded[DATA_WIDTH-1:0];
        end
    end

    // Output register is written once per frame and held until the next scale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mean <= '0;
        end else if (scale) begin
            mean <= sat;
        end
    end

endmodule

// File: rtl/se_gap_stream.sv
// rtl/se_gap_stream.sv - streaming global average pool top (FSM, pixel counter, lanes); optional SE_GAP_FRAME_CHECK_EN
module se_gap_stream
    import se_pkg::*;
#(
    parameter int IN_SIZE     = 16,
    parameter int IN_HEIGHT   = 56,
    parameter int IN_WIDTH    = 56,
    parameter int DATA_WIDTH  = 8,
    parameter int FRAC_BITS   = 4,
    parameter int RECIP_SHIFT = 24
) (
    input  logic           clk,
    input  logic           rst,
    se_gap_stream_if.slave bus
);

    localparam int N     = IN_HEIGHT * IN_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // The mean keeps the input's binary point, so the fraction must fit the sample
    if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_frac_bits_invalid
        $error("FRAC_BITS must lie within DATA_WIDTH");
    end

    gap_state_e                         state;
    gap_state_e                         state_nxt;
    logic [CNT_W-1:0]                   pix_cnt;
    logic                               s_ready_c;
    logic                               m_valid_c;
    logic                               scale;
    logic                               accept;
    logic                               last_pix;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0] mean_vec;

    assign accept   = bus.s_valid && s_ready_c;
    assign last_pix = (pix_cnt == CNT_W'(N - 1));

    // State register; reset drops m_valid immediately since it decodes from state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        s_ready_c = 1'b0;
        m_valid_c = 1'b0;
        scale     = 1'b0;
        unique case (state)
            ACCUM: begin
                s_ready_c = 1'b1;
                if (bus.s_valid && last_pix) begin
                    state_nxt = SCALE;
                end
            end
            SCALE: begin
                scale     = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                m_valid_c = 1'b1;
                if (bus.m_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Pixel counter is the authority on frame boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        end
    end

    for (genvar c = 0; c < IN_SIZE; c++) begin : g_lane
        se_gap_lane #(
            .N           (N),
            .DATA_WIDTH  (DATA_WIDTH),
            .RECIP_SHIFT (RECIP_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .acc_load (accept && (pix_cnt == '0)),
            .acc_add  (accept && (pix_cnt != '0)),
            .scale    (scale),
            .sample   (bus.s_data[c]),
            .mean     (mean_vec[c])
        );
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_c;
    assign bus.m_data  = mean_vec;

`ifdef SE_GAP_FRAME_CHECK_EN
    logic frame_err_q;

    // Sticky flag when s_last disagrees with the counter's notion of the last pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else if (accept && (bus.s_last != last_pix)) begin
            frame_err_q <= 1'b1;
        end
    end

    assign bus.frame_err = frame_err_q;
`endif

endmodule
